// File: rtl/signed_seq_divider_pkg.sv
// Shared definitions for the signed sequential divider: default widths,
// the controller state encoding and the iteration-counter width helper.
package div_pkg;

  // Default dividend/quotient and divisor/remainder widths.
  localparam int DEF_DW = 16;
  localparam int DEF_VW = 8;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width of the iteration counter that runs 0..dw-1.
  function automatic int cnt_w(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/signed_seq_divider_if.sv
// Operand/result handshake bundle for the signed sequential divider.
// The master side presents operands and consumes results; the slave side
// is the divider itself.
interface signed_seq_divider_if #(
  parameter int DW = 16,
  parameter int VW = 8
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  logic          overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/signed_seq_divider_sign_mag_conv.sv
// Conditional two's-complement negation. With neg_en tied to the operand's
// MSB it yields the unsigned magnitude (so the most negative value maps to
// 2^(W-1)); with neg_en driven by a captured sign it re-applies that sign.
module sign_mag_conv #(
  parameter int W = 8
) (
  input  logic [W-1:0] din,
  input  logic         neg_en,
  output logic [W-1:0] dout
);

  logic [W-1:0] inv;

  // Invert every bit when negating; the +1 is added below.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_inv
      assign inv[gi] = din[gi] ^ neg_en;
    end
  endgenerate

  assign dout = inv + W'(neg_en);

endmodule

// File: rtl/signed_seq_divider.sv
// Signed DW-by-VW radix-2 restoring divider with valid/ready handshakes.
// Operands are converted to magnitudes on capture, divided MSB-first over
// DW cycles, then sign-corrected in a single FIX cycle. Quotient truncates
// toward zero; the remainder takes the sign of the dividend.
module signed_seq_divider
  import div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic                clk,
  input  logic                rst,
  signed_seq_divider_if.slave bus
);

  localparam int CW = cnt_w(DW);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [VW:0]   prem_reg;       // partial remainder, one guard bit wide
  logic [DW-1:0] quo_reg;        // dividend bits shift out, quotient bits shift in
  logic [VW-1:0] dvs_reg;        // |divisor|
  logic          sign_q_reg;
  logic          sign_r_reg;
  logic          ovf_cap_reg;
  logic          dbz_cap_reg;

  logic [DW-1:0] quotient_reg;
  logic [VW-1:0] remainder_reg;
  logic          dbz_reg;
  logic          ovf_reg;

  logic [DW-1:0] dividend_mag;
  logic [VW-1:0] divisor_mag;
  logic [DW-1:0] quotient_fix;
  logic [VW-1:0] remainder_fix;
  logic          rem_neg;

  logic [VW+1:0] shifted;
  logic [VW+1:0] trial;
  logic          trial_neg;

  // Operand magnitudes on entry.
  sign_mag_conv #(.W(DW)) u_abs_dividend (
    .din    (bus.dividend),
    .neg_en (bus.dividend[DW-1]),
    .dout   (dividend_mag)
  );

  sign_mag_conv #(.W(VW)) u_abs_divisor (
    .din    (bus.divisor),
    .neg_en (bus.divisor[VW-1]),
    .dout   (divisor_mag)
  );

  // Sign re-application for the results. A zero remainder is never negated.
  assign rem_neg = sign_r_reg && (prem_reg[VW-1:0] != '0);

  sign_mag_conv #(.W(DW)) u_fix_quotient (
    .din    (quo_reg),
    .neg_en (sign_q_reg),
    .dout   (quotient_fix)
  );

  sign_mag_conv #(.W(VW)) u_fix_remainder (
    .din    (prem_reg[VW-1:0]),
    .neg_en (rem_neg),
    .dout   (remainder_fix)
  );

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  // The partial remainder stays below |divisor| <= 2^(VW-1), so the shifted
  // value always fits in VW+1 bits and bit VW+1 of the difference is its sign.
  always_comb begin
    shifted   = {prem_reg, quo_reg[DW-1]};
    trial     = shifted - {2'b00, dvs_reg};
    trial_neg = trial[VW+1];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; a zero divisor skips the iterations and goes to FIX.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.in_valid) state_next = (bus.divisor == '0) ? FIX : CALC;
      CALC: if (cnt_reg == CW'(DW - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      prem_reg      <= '0;
      quo_reg       <= '0;
      dvs_reg       <= '0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      ovf_cap_reg   <= 1'b0;
      dbz_cap_reg   <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            quo_reg     <= dividend_mag;
            dvs_reg     <= divisor_mag;
            sign_q_reg  <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
            sign_r_reg  <= bus.dividend[DW-1];
            cnt_reg     <= '0;
            prem_reg    <= '0;
            dbz_cap_reg <= (bus.divisor == '0);
            ovf_cap_reg <= (bus.dividend == {1'b1, {(DW-1){1'b0}}}) &&
                           (bus.divisor == '1);
          end
        end
        CALC: begin
          prem_reg <= trial_neg ? shifted[VW:0] : trial[VW:0];
          quo_reg  <= {quo_reg[DW-2:0], ~trial_neg};
          cnt_reg  <= cnt_reg + CW'(1);
        end
        FIX: begin
          if (dbz_cap_reg) begin
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b1;
            ovf_reg       <= 1'b0;
          end else begin
            // The most-negative / -1 case wraps naturally to 0x8000.
            quotient_reg  <= quotient_fix;
            remainder_reg <= remainder_fix;
            dbz_reg       <= 1'b0;
            ovf_reg       <= ovf_cap_reg;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and result outputs.
  always_comb begin
    bus.in_ready    = (state_reg == IDLE);
    bus.out_valid   = (state_reg == DONE);
    bus.quotient    = quotient_reg;
    bus.remainder   = remainder_reg;
    bus.div_by_zero = dbz_reg;
    bus.overflow    = ovf_reg;
  end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Directed bench for signed_seq_divider: sign combinations, boundary
// operands, divide-by-zero, result backpressure and mid-division reset.
module tb_signed_seq_divider;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  signed_seq_divider_if #(.DW(16), .VW(8)) dif ();

  signed_seq_divider #(.DW(16), .VW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for out_valid after a capture edge; returns edges elapsed.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (dif.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_div(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                         input logic [15:0] eq, input logic [7:0] er,
                         input logic edbz, input logic eovf, input int elat);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(dif.in_ready), 32'd1);
    dif.in_valid = 1'b1;
    dif.dividend = dd;
    dif.divisor  = dv;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    wait_valid(lat);
    chk({tag, ".latency"}, 32'(lat), 32'(elat));
    chk({tag, ".quotient"}, 32'(dif.quotient), 32'(eq));
    chk({tag, ".remainder"}, 32'(dif.remainder), 32'(er));
    chk({tag, ".div_by_zero"}, 32'(dif.div_by_zero), 32'(edbz));
    chk({tag, ".overflow"}, 32'(dif.overflow), 32'(eovf));
    $display("txn %s: %h / %h -> q=%h r=%h dbz=%b ovf=%b lat=%0d", tag, dd, dv,
             dif.quotient, dif.remainder, dif.div_by_zero, dif.overflow, lat);
    @(negedge clk);
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    chk({tag, ".drain_in_ready"}, 32'(dif.in_ready), 32'd1);
    chk({tag, ".drain_out_valid"}, 32'(dif.out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    dif.in_valid  = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    dif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.in_ready", 32'(dif.in_ready), 32'd1);
    chk("reset.out_valid", 32'(dif.out_valid), 32'd0);
    chk("reset.quotient", 32'(dif.quotient), 32'd0);
    chk("reset.remainder", 32'(dif.remainder), 32'd0);
    chk("reset.div_by_zero", 32'(dif.div_by_zero), 32'd0);
    chk("reset.overflow", 32'(dif.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle with in_valid low: nothing moves.
    repeat (5) @(posedge clk);
    #1;
    chk("idle.in_ready", 32'(dif.in_ready), 32'd1);
    chk("idle.out_valid", 32'(dif.out_valid), 32'd0);

    run_div("p100_p7",  16'd100,  8'd7,    16'd14,   8'd2,    1'b0, 1'b0, 17);
    run_div("m100_p7",  16'hFF9C, 8'd7,    16'hFFF2, 8'hFE,   1'b0, 1'b0, 17);
    run_div("p100_m7",  16'd100,  8'hF9,   16'hFFF2, 8'd2,    1'b0, 1'b0, 17);
    run_div("m128_p1",  16'hFF80, 8'd1,    16'hFF80, 8'd0,    1'b0, 1'b0, 17);
    run_div("m275_m128",16'hFEED, 8'h80,   16'd2,    8'hED,   1'b0, 1'b0, 17);
    run_div("min_m1",   16'h8000, 8'hFF,   16'h8000, 8'd0,    1'b0, 1'b1, 17);
    run_div("p55_z",    16'd55,   8'd0,    16'd0,    8'd0,    1'b1, 1'b0, 1);

    // Backpressure: 300 / -9 held in DONE while a second pair (-77 / 5) waits.
    @(negedge clk);
    dif.in_valid = 1'b1;
    dif.dividend = 16'd300;
    dif.divisor  = 8'hF7;
    @(posedge clk); #1;
    dif.dividend = 16'hFFB3;
    dif.divisor  = 8'd5;
    wait_valid(lat);
    chk("bp1.latency", 32'(lat), 32'd17);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp1.hold_quotient", 32'(dif.quotient), 32'h0000FFDF);
      chk("bp1.hold_remainder", 32'(dif.remainder), 32'd3);
      chk("bp1.hold_out_valid", 32'(dif.out_valid), 32'd1);
      chk("bp1.hold_in_ready", 32'(dif.in_ready), 32'd0);
    end
    $display("txn bp1: 012c / f7 -> q=%h r=%h held 5 cycles", dif.quotient, dif.remainder);
    @(negedge clk);
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    chk("bp1.handoff_in_ready", 32'(dif.in_ready), 32'd1);
    chk("bp1.handoff_out_valid", 32'(dif.out_valid), 32'd0);
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    chk("bp2.captured", 32'(dif.in_ready), 32'd0);
    wait_valid(lat);
    chk("bp2.latency", 32'(lat), 32'd17);
    chk("bp2.quotient", 32'(dif.quotient), 32'h0000FFF1);
    chk("bp2.remainder", 32'(dif.remainder), 32'h000000FE);
    $display("txn bp2: ffb3 / 05 -> q=%h r=%h lat=%0d", dif.quotient, dif.remainder, lat);
    @(negedge clk);
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    chk("bp2.drain_in_ready", 32'(dif.in_ready), 32'd1);

    // Reset during iteration 8 of 12345 / 3.
    @(negedge clk);
    dif.in_valid = 1'b1;
    dif.dividend = 16'd12345;
    dif.divisor  = 8'd3;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid.in_ready", 32'(dif.in_ready), 32'd1);
    chk("rst_mid.out_valid", 32'(dif.out_valid), 32'd0);
    chk("rst_mid.quotient", 32'(dif.quotient), 32'd0);
    chk("rst_mid.remainder", 32'(dif.remainder), 32'd0);
    chk("rst_mid.div_by_zero", 32'(dif.div_by_zero), 32'd0);
    chk("rst_mid.overflow", 32'(dif.overflow), 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (dif.out_valid === 1'b1) seen++;
    end
    chk("rst_mid.no_result", 32'(seen), 32'd0);
    $display("txn rst_mid: 3039 / 03 aborted at iteration 8");

    run_div("p1000_p10", 16'd1000, 8'd10, 16'd100, 8'd0, 1'b0, 1'b0, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
